// File: rtl/simple_processor_pkg.sv
// rtl/simple_processor_pkg.sv - shared width, feeder state encoding and opcode constants
package simple_processor_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        HALTED,
        ERROR,
        STEP_WAIT
    } state_t;

    localparam logic [2:0] OP_MV  = 3'd0;
    localparam logic [2:0] OP_MVT = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_LD  = 3'd4;
    localparam logic [2:0] OP_ST  = 3'd5;
    localparam logic [2:0] OP_AND = 3'd6;
    localparam logic [2:0] OP_B   = 3'd7;

    // Instruction word: {opcode, immediate flag, rX, 9-bit rY/immediate field}
    function automatic logic [DATA_W-1:0] make_instr(input logic [2:0] op, input logic imm,
                                                     input logic [2:0] rx, input logic [8:0] operand);
        return {op, imm, rx, operand};
    endfunction

endpackage

// File: rtl/program_ram.sv
// rtl/program_ram.sv - single-port synchronous program RAM, write-first, 1-cycle read
module program_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // Array has no reset so the program survives a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only moves on re, so it doubles as the held instruction word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/instruction_feeder.sv
// rtl/instruction_feeder.sv - program sequencer for simple_processor; SINGLE_STEP_EN adds step/step_mode
module instruction_feeder #(
    parameter int DATA_W  = simple_processor_pkg::DATA_W,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
`ifdef SINGLE_STEP_EN
    input  logic              step,
    input  logic              step_mode,
`endif
    output logic [DATA_W-1:0] DIN,
    output logic              run,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [ADDR_W-1:0] pc
);

    import simple_processor_pkg::*;

    localparam int WDOG_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [WDOG_W-1:0] wdog;
    logic [ADDR_W:0]   clamped_len;
    logic              idle_like;
    logic              ram_we;
    logic              ram_re;
    logic              last;

    assign idle_like   = (state == IDLE) || (state == HALTED) || (state == ERROR);
    assign ram_we      = wr_en && idle_like;
    assign ram_re      = (state == FETCH);
    assign clamped_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last        = ({1'b0, pc} == (len - LEN_ONE));

    program_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk_50MHz),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_we ? wr_addr : pc),
        .wdata (wr_data),
        .rdata (DIN)
    );

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state  <= IDLE;
            run    <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
            error  <= 1'b0;
            pc     <= '0;
            len    <= '0;
            wdog   <= '0;
        end else begin
            run <= 1'b0;
            case (state)
                IDLE, HALTED, ERROR: begin
                    if (start) begin
                        error <= 1'b0;
                        pc    <= '0;
                        len   <= clamped_len;
                        if (clamped_len == '0) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state  <= FETCH;
                            halted <= 1'b0;
                            busy   <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state <= ISSUE;
                    run   <= 1'b1;
                    wdog  <= '0;
                end
                ISSUE: begin
                    state <= WAIT;
                    wdog  <= wdog + WDOG_W'(1);
                end
                WAIT: begin
                    // A done on the expiry cycle still retires the instruction.
                    if (done) begin
                        if (last) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            pc <= pc + ADDR_W'(1);
`ifdef SINGLE_STEP_EN
                            state <= step_mode ? STEP_WAIT : FETCH;
`else
                            state <= FETCH;
`endif
                        end
                    end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                        state <= ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
`ifdef SINGLE_STEP_EN
                STEP_WAIT: begin
                    if (step) begin
                        state <= FETCH;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
